// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer
//   Frame sequencer for one butterfly stage of the 16-lane parallel FFT.
//   It frames incoming beats into frames of BEATS beats. It drives the stage
//   valid and the twiddle index, and regenerates the output enable, SOF and
//   EOF LAT cycles after each accepted beat. It also flags framing errors and
//   counts completed frames.
// Ports
//   clk, rstn    clock (rising edge), asynchronous active-low reset
//   din_valid    upstream beat valid, no backpressure
//   din_sof      first beat of frame, qualified by din_valid
//   bf_valid     combinational: beat accepted into the butterfly stage
//   tw_idx       twiddle select, beat index mod 2^TW_W, one cycle after accept
//   bf_o_en      stage output valid, LAT cycles after accept
//   dout_sof     with bf_o_en: output beat 0
//   dout_eof     with bf_o_en: output beat BEATS-1
//   frame_done   one-cycle pulse after the EOF beat is output
//   frame_cnt    completed-frame counter, wraps
//   busy         input frame open or any tag in flight
//   err_sof      one-cycle pulse, SOF protocol violation
//   err_gap      one-cycle pulse, din_valid dropped mid-frame
module fft_stage_sequencer #(
    parameter int unsigned BEATS  = 32,
    parameter int unsigned LAT    = 2,
    parameter int unsigned TW_W   = 2,
    parameter int unsigned FCNT_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              din_valid,
    input  logic              din_sof,
    output logic              bf_valid,
    output logic [TW_W-1:0]   tw_idx,
    output logic              bf_o_en,
    output logic              dout_sof,
    output logic              dout_eof,
    output logic              frame_done,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              busy,
    output logic              err_sof,
    output logic              err_gap
);

    localparam int unsigned CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic valid;
        logic sof;
        logic eof;
    } tag_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] in_cnt_nx;
    logic [CNT_W-1:0] beat_idx;
    tag_t             tags    [LAT];
    tag_t             tags_nx [LAT];

    logic sof_beat;
    logic run_beat;
    logic last_beat;
    logic abort;
    logic sof_err;
    logic gap_err;
    logic done_now;
    logic busy_nx;

    // Beat decode, next input state and next tag pipeline contents.
    always_comb begin
        sof_beat  = din_valid & din_sof;
        run_beat  = din_valid & ~din_sof & (state == RUN);
        last_beat = run_beat & (in_cnt == LAST_BEAT);
        abort     = (state == RUN) & (~din_valid | din_sof);
        sof_err   = din_valid & ((state == RUN) ? din_sof : ~din_sof);
        gap_err   = (state == RUN) & ~din_valid;
        bf_valid  = sof_beat | run_beat;
        beat_idx  = sof_beat ? '0 : in_cnt;
        done_now  = tags[LAT-1].valid & tags[LAT-1].eof;

        state_nx  = state;
        in_cnt_nx = in_cnt;
        if (sof_beat) begin
            state_nx  = RUN;
            in_cnt_nx = CNT_W'(1);
        end else if (run_beat) begin
            if (last_beat) begin
                state_nx  = IDLE;
                in_cnt_nx = '0;
            end else begin
                in_cnt_nx = in_cnt + CNT_W'(1);
            end
        end else if (gap_err) begin
            state_nx  = IDLE;
            in_cnt_nx = '0;
        end

        tags_nx[0].valid = bf_valid;
        tags_nx[0].sof   = sof_beat;
        tags_nx[0].eof   = last_beat;
        // Inside a frame beats arrive every cycle, so the aborted frame
        // occupies exactly the in_cnt youngest stages; after the shift
        // those are stages 1..in_cnt. Older frames keep draining.
        for (int unsigned i = 1; i < LAT; i++) begin
            tags_nx[i] = tags[i-1];
            if (abort && (i <= 32'(in_cnt))) begin
                tags_nx[i] = '0;
            end
        end

        busy_nx = (state_nx == RUN);
        for (int unsigned i = 0; i < LAT; i++) begin
            busy_nx = busy_nx | tags_nx[i].valid;
        end
    end

    // State, counters, tag pipeline and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            in_cnt     <= '0;
            tw_idx     <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            busy       <= 1'b0;
            err_sof    <= 1'b0;
            err_gap    <= 1'b0;
            for (int unsigned i = 0; i < LAT; i++) begin
                tags[i] <= '0;
            end
        end else begin
            state      <= state_nx;
            in_cnt     <= in_cnt_nx;
            frame_done <= done_now;
            busy       <= busy_nx;
            err_sof    <= sof_err;
            err_gap    <= gap_err;
            if (bf_valid) begin
                tw_idx <= TW_W'(beat_idx);
            end
            if (done_now) begin
                frame_cnt <= frame_cnt + FCNT_W'(1);
            end
            for (int unsigned i = 0; i < LAT; i++) begin
                tags[i] <= tags_nx[i];
            end
        end
    end

    assign bf_o_en  = tags[LAT-1].valid;
    assign dout_sof = tags[LAT-1].sof;
    assign dout_eof = tags[LAT-1].eof;

endmodule
